mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration in cycles of mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration in cycles of div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  decoder strobe; qualifies a mult/multu/div/divu request in the E stage.
REQ-006 HILO_Op  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
REQ-007 A  input  32  rs operand (forwarded).
REQ-008 B  input  32  rt operand (forwarded).
REQ-009 busy  output  1  registered; high while a mult/div is in flight.
REQ-010 HILO_out  output  32  read data for mfhi/mflo.

Function
REQ-011 Internal state SHALL be HI[31:0], LO[31:0], busy, a down-counter wide enough for max(MULT_CYCLES, DIV_CYCLES), and 64-bit pending-result registers.
REQ-012 FSM SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-013 In IDLE, start=1 with HILO_Op in 1..4 SHALL latch the computed result, load the counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4), and enter RUN on that edge.
REQ-014 In IDLE, start=1 with HILO_Op outside 1..4 SHALL be ignored.
REQ-015 In RUN, the counter SHALL decrement each cycle; on the edge where it reaches 0 the pending result SHALL be written to HI/LO and the FSM SHALL return to IDLE; busy is therefore high for exactly N cycles after the start edge.
REQ-016 mult: {HI,LO} = signed(A) * signed(B), full 64-bit product.
REQ-017 multu: {HI,LO} = unsigned(A) * unsigned(B), full 64-bit product.
REQ-018 div: LO = signed quotient truncated toward zero, HI = signed remainder with sign of A; 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-019 divu: LO = unsigned quotient, HI = unsigned remainder.
REQ-020 Division by B=0 SHALL still run DIV_CYCLES with busy asserted but SHALL leave HI and LO unchanged at completion.
REQ-021 HI/LO SHALL NOT change during RUN except on the completion edge.
REQ-022 In IDLE, HILO_Op=7 SHALL write A to HI and HILO_Op=8 SHALL write A to LO on the next edge, independent of start.
REQ-023 In RUN, any start, mthi or mtlo SHALL be ignored; the upstream hazard unit stalls on (start | busy | HILO_Op in 5..8 while busy).
REQ-024 HILO_out SHALL be combinational: HI when HILO_Op=5, LO when HILO_Op=6, else 0; it SHALL reflect the current registered HI/LO.
REQ-025 On the completion edge, a same-cycle mthi/mtlo SHALL be ignored (RUN-state rule) and the pending result wins.

Reset
REQ-026 reset=0 SHALL asynchronously clear HI, LO, counter, pending result and busy to 0 and force IDLE.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no result SHALL be committed afterwards, and busy SHALL be 0 on the first edge after release.
REQ-028 The first start after reset release SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-029 mult: A=0xFFFFFFFE(-2), B=0x00000003, start=1 op=1 for one cycle -> busy=1 for 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 multu then mfhi: A=0xFFFFFFFF, B=0x00000002, op=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; op=5 -> HILO_out=0x00000001.
REQ-031 div: A=0xFFFFFFF9(-7), B=0x00000002, op=3 -> busy for 10 cycles; then LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); divu with A=7, B=2 -> LO=3, HI=1.
REQ-032 Divide by zero: HI=0x11111111, LO=0x22222222 via mthi/mtlo, then div with B=0 -> busy 10 cycles, HI/LO unchanged.
REQ-033 Ignore while busy: start mult, then on cycle 2 apply op=7 A=0xDEADBEEF and start div -> neither takes effect; mult result is committed at cycle 5; busy returns to 0.
REQ-034 Reset mid-op: start div, pull reset low at cycle 4 for 1 cycle -> busy=0, HI=LO=0 immediately and remain 0 through 10+ cycles.

Source files
------------

// File: rtl/mdu.sv
// mdu -- multi-cycle multiply/divide unit with HI/LO registers.
//
// mult/multu/div/divu compute their 64-bit result in the cycle they are
// started. The result waits in pending registers while busy is held for
// MULT_CYCLES or DIV_CYCLES. It is written into HI/LO on the edge where
// the down-counter reaches zero. mthi/mtlo write HI/LO directly, but only
// while idle. mfhi/mflo read HI/LO combinationally.
//
// Ports:
//   clk       single clock, rising edge
//   reset     asynchronous, active-low reset
//   start     qualifies a mult/multu/div/divu request
//   HILO_Op   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//             5 mfhi, 6 mflo, 7 mthi, 8 mtlo
//   A, B      rs / rt operands
//   busy      high while a mult/div is in flight (registered)
//   HILO_out  HI for mfhi, LO for mflo, else 0
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  HILO_Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HILO_out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   hi, lo;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_wr;
    logic          accept, commit;

    logic is_mul, is_div;
    assign is_mul = (HILO_Op == 4'd1) || (HILO_Op == 4'd2);
    assign is_div = (HILO_Op == 4'd3) || (HILO_Op == 4'd4);

    // Signed division is done on magnitudes and the signs are fixed up
    // afterwards. This keeps 0x80000000 / -1 well defined (it gives 0x80000000).
    // A zero divisor is replaced by 1 so the datapath never sees x/0. The
    // result is discarded in that case anyway.
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, bs_div, bu_div;
    logic [31:0] qs_mag, rs_mag, q_s, r_s, q_u, r_u;
    logic [63:0] result;

    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        a_mag  = A[31] ? (~A + 32'd1) : A;
        b_mag  = B[31] ? (~B + 32'd1) : B;
        bs_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
        bu_div = (B == 32'd0) ? 32'd1 : B;
        qs_mag = a_mag / bs_div;
        rs_mag = a_mag % bs_div;
        q_s    = (A[31] ^ B[31]) ? (~qs_mag + 32'd1) : qs_mag;
        r_s    = A[31] ? (~rs_mag + 32'd1) : rs_mag;
        q_u    = A / bu_div;
        r_u    = A % bu_div;
        case (HILO_Op)
            4'd1:    result = prod_s;
            4'd2:    result = prod_u;
            4'd3:    result = {r_s, q_s};
            4'd4:    result = {r_u, q_u};
            default: result = 64'd0;
        endcase
    end

    // Next-state logic. The counter holds the number of busy cycles left, so
    // the run completes on the edge that takes it from 1 to 0.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: if (start && (is_mul || is_div)) begin
                accept  = 1'b1;
                state_n = RUN;
            end
            RUN: if (cnt <= CW'(1)) begin
                commit  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (accept) begin
                cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                pend_hi <= result[63:32];
                pend_lo <= result[31:0];
                pend_wr <= !(is_div && (B == 32'd0));
            end else if (state == RUN) begin
                cnt <= commit ? '0 : cnt - CW'(1);
            end

            // mthi/mtlo only while idle; the completion edge is still RUN,
            // so the pending result wins over a same-cycle move.
            if (commit) begin
                if (pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end else if (state == IDLE) begin
                if (HILO_Op == 4'd7) hi <= A;
                if (HILO_Op == 4'd8) lo <= A;
            end
        end
    end

    assign busy = (state == RUN);

    always_comb begin
        case (HILO_Op)
            4'd5:    HILO_out = hi;
            4'd6:    HILO_out = lo;
            default: HILO_out = 32'd0;
        endcase
    end

endmodule
